// File: rtl/riscv_mem_pkg.sv
// Shared types for the riscv_core memory responder and its store buffer.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/riscv_mem_responder_if.sv
// Loader, core and debug signals between riscv_core-side logic and the memory responder.
interface riscv_mem_responder_if;

    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        load_done;
    logic        core_rst;
    logic [31:0] core_addr;
    logic [31:0] core_din;
    logic [31:0] core_mem_addr;
    logic        core_en;
    logic        core_rw;
    logic [31:0] core_ddatout;
    logic [31:0] core_ddatin;
    logic        core_trap;
    logic        dbg_wr_en;
    logic        dbg_rd_en;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic [31:0] dbg_rdata;
    logic        dbg_rvalid;

    modport master (
        output load_valid, load_addr, load_data, load_done,
        output core_addr, core_mem_addr, core_en, core_rw, core_ddatout, core_trap,
        output dbg_wr_en, dbg_rd_en, dbg_addr, dbg_wdata,
        input  load_ready, core_rst, core_din, core_ddatin, dbg_rdata, dbg_rvalid
    );

    modport slave (
        input  load_valid, load_addr, load_data, load_done,
        input  core_addr, core_mem_addr, core_en, core_rw, core_ddatout, core_trap,
        input  dbg_wr_en, dbg_rd_en, dbg_addr, dbg_wdata,
        output load_ready, core_rst, core_din, core_ddatin, dbg_rdata, dbg_rvalid
    );

endinterface

// File: rtl/riscv_wbuf.sv
// Circular store buffer with youngest-entry forwarding lookup by word index.
module riscv_wbuf
    import riscv_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  wbuf_entry_t            push_entry,
    input  logic                   pop,
    output wbuf_entry_t            head_entry,
    output logic [$clog2(DEPTH):0] count,
    input  logic [31:0]            lookup_idx,
    output logic                   hit,
    output logic [31:0]            hit_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    wbuf_entry_t      entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    assign head_entry = entries[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                entries[tail] <= push_entry;
                tail          <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Walk oldest to youngest so the last match found is the youngest store.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((PTR_W+1)'(i) < count && entries[head + PTR_W'(i)].idx == lookup_idx) begin
                hit      = 1'b1;
                hit_data = entries[head + PTR_W'(i)].data;
            end
        end
    end

endmodule

// File: rtl/riscv_mem_responder.sv
// Memory-side responder for riscv_core: imem boot loader, data memory, debug port, fault tracking.
// Define RISCV_MEM_WBUF_EN to route core stores through riscv_wbuf with read forwarding.
module riscv_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 1024,
    parameter int unsigned DMEM_WORDS = 1024,
    parameter logic [31:0] IMEM_BASE  = 32'h8000_0000,
    parameter logic [31:0] DMEM_BASE  = 32'h0000_0000,
    parameter int unsigned WBUF_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    riscv_mem_responder_if.slave        bus,
    output logic [1:0]                  state,
    output logic [$clog2(WBUF_DEPTH):0] wbuf_count,
    output logic                        bus_err,
    output logic                        ovf_err
);

    localparam int unsigned IA_W = $clog2(IMEM_WORDS);
    localparam int unsigned DA_W = $clog2(DMEM_WORDS);

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];

    state_t      st;
    logic [31:0] fetch_idx;
    logic [31:0] data_idx;
    logic        fetch_ok;
    logic        data_ok;
    logic        dbg_ok;
    logic        ovf_event;

    assign state     = st;
    assign fetch_idx = bus.core_addr - IMEM_BASE;
    assign data_idx  = (bus.core_mem_addr - DMEM_BASE) >> 2;
    assign fetch_ok  = fetch_idx < IMEM_WORDS;
    assign data_ok   = data_idx < DMEM_WORDS;
    assign dbg_ok    = bus.dbg_addr < DMEM_WORDS;

    assign bus.core_din = fetch_ok ? imem[fetch_idx[IA_W-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            st             <= ST_LOAD;
            bus.load_ready <= 1'b1;
            bus.core_rst   <= 1'b0;
        end else begin
            case (st)
                ST_LOAD: if (bus.load_done) begin
                    st             <= ST_RUN;
                    bus.load_ready <= 1'b0;
                    bus.core_rst   <= 1'b1;
                end
                ST_RUN: if (bus.core_trap || ovf_event) begin
                    st           <= ST_FAULT;
                    bus.core_rst <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (bus.load_ready && bus.load_valid && bus.load_addr < IMEM_WORDS) begin
            imem[bus.load_addr[IA_W-1:0]] <= bus.load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err        <= 1'b0;
            bus.dbg_rvalid <= 1'b0;
            bus.dbg_rdata  <= '0;
        end else begin
            bus_err        <= bus.core_en && !data_ok;
            bus.dbg_rvalid <= bus.dbg_rd_en;
            if (bus.dbg_rd_en) begin
                bus.dbg_rdata <= dbg_ok ? dmem[bus.dbg_addr[DA_W-1:0]] : '0;
            end
        end
    end

`ifdef RISCV_MEM_WBUF_EN
    localparam int unsigned                 CNT_W      = $clog2(WBUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0]            FULL_COUNT = CNT_W'(WBUF_DEPTH);

    wbuf_entry_t push_entry;
    wbuf_entry_t head_entry;
    logic        store_req;
    logic        full;
    logic        push;
    logic        pop;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    assign store_req  = (st == ST_RUN) && bus.core_en && bus.core_rw && data_ok;
    assign full       = wbuf_count == FULL_COUNT;
    assign pop        = !rst && !bus.dbg_wr_en && wbuf_count != '0;
    // A full buffer still accepts a store when the head drains on the same edge.
    assign push       = store_req && (!full || pop);
    assign ovf_event  = store_req && full && !pop;
    assign push_entry = '{idx: data_idx, data: bus.core_ddatout};

    riscv_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .count      (wbuf_count),
        .lookup_idx (data_idx),
        .hit        (fwd_hit),
        .hit_data   (fwd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (bus.dbg_wr_en) begin
                if (dbg_ok) dmem[bus.dbg_addr[DA_W-1:0]] <= bus.dbg_wdata;
            end else if (pop) begin
                dmem[head_entry.idx[DA_W-1:0]] <= head_entry.data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_err <= 1'b0;
        else if (ovf_event) ovf_err <= 1'b1;
    end

    assign bus.core_ddatin = !data_ok ? '0 : fwd_hit ? fwd_data : dmem[data_idx[DA_W-1:0]];
`else
    assign ovf_event  = 1'b0;
    assign ovf_err    = 1'b0;
    assign wbuf_count = '0;

    // Core stores and debug writes never collide: debug writes only land outside RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (st == ST_RUN && bus.core_en && bus.core_rw && data_ok) begin
                dmem[data_idx[DA_W-1:0]] <= bus.core_ddatout;
            end else if (st != ST_RUN && bus.dbg_wr_en && dbg_ok) begin
                dmem[bus.dbg_addr[DA_W-1:0]] <= bus.dbg_wdata;
            end
        end
    end

    assign bus.core_ddatin = data_ok ? dmem[data_idx[DA_W-1:0]] : '0;
`endif

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Bench for riscv_mem_responder: vector table for fetch/load paths, sequences for store, overflow and fault.
module tb_riscv_mem_responder;

`ifdef RISCV_MEM_WBUF_EN
    localparam bit WBUF = 1'b1;
`else
    localparam bit WBUF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state;
    logic [2:0] wbuf_count;
    logic       bus_err;
    logic       ovf_err;

    riscv_mem_responder_if bus ();

    riscv_mem_responder #(
        .IMEM_WORDS (1024),
        .DMEM_WORDS (1024),
        .IMEM_BASE  (32'h8000_0000),
        .DMEM_BASE  (32'h0000_0000),
        .WBUF_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .state      (state),
        .wbuf_count (wbuf_count),
        .bus_err    (bus_err),
        .ovf_err    (ovf_err)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sb_q [$];

    typedef struct {
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic        en;
        logic [31:0] exp_din;
        logic [31:0] exp_ddat;
        logic        exp_berr;
    } vec_t;

    vec_t        vt [7];
    logic [31:0] iw [3];
    logic [31:0] dw [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_read(input logic [31:0] idx, input logic [31:0] exp);
        bus.dbg_rd_en = 1'b1;
        bus.dbg_addr  = idx;
        sb_q.push_back(exp);
        tick();
        bus.dbg_rd_en = 1'b0;
        tick();
    endtask

    // Debug read results are compared against the queue as they come out.
    always @(negedge clk) begin
        if (bus.dbg_rvalid === 1'b1) begin
            if (sb_q.size() == 0) check("dbg_rvalid_unexpected", 32'(bus.dbg_rvalid), 32'd0);
            else check("dbg_rdata", bus.dbg_rdata, sb_q.pop_front());
        end
    end

    initial begin
        iw = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113};
        dw = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
        vt[0] = '{32'h8000_0000, 32'h0000_0000, 1'b1, iw[0], dw[0], 1'b0};
        vt[1] = '{32'h8000_0001, 32'h0000_0004, 1'b1, iw[1], dw[1], 1'b0};
        vt[2] = '{32'h8000_0002, 32'h0000_0007, 1'b1, iw[2], dw[1], 1'b0};
        vt[3] = '{32'h7FFF_FFFF, 32'h0000_1000, 1'b1, 32'h0,  32'h0,  1'b1};
        vt[4] = '{32'h8000_0400, 32'hFFFF_FFFC, 1'b1, 32'h0,  32'h0,  1'b1};
        vt[5] = '{32'h0000_0000, 32'h0000_1000, 1'b0, 32'h0,  32'h0,  1'b0};
        vt[6] = '{32'h8000_0000, 32'h0000_000C, 1'b1, iw[0], dw[3], 1'b0};

        rst = 1'b1;
        bus.load_valid = 1'b0; bus.load_addr = '0; bus.load_data = '0; bus.load_done = 1'b0;
        bus.core_addr = '0; bus.core_mem_addr = '0; bus.core_en = 1'b0; bus.core_rw = 1'b0;
        bus.core_ddatout = '0; bus.core_trap = 1'b0;
        bus.dbg_wr_en = 1'b0; bus.dbg_rd_en = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
        tick();
        tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_core_rst", 32'(bus.core_rst), 32'd0);
        check("rst_load_ready", 32'(bus.load_ready), 32'd1);
        check("rst_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        check("rst_dbg_rdata", bus.dbg_rdata, 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_ovf_err", 32'(ovf_err), 32'd0);
        check("rst_wbuf_count", 32'(wbuf_count), 32'd0);
        rst = 1'b0;

        // Preload dmem through the debug port while still in LOAD.
        for (int k = 0; k < 4; k++) begin
            bus.dbg_wr_en = 1'b1; bus.dbg_addr = 32'(k); bus.dbg_wdata = dw[k];
            tick();
        end
        bus.dbg_wr_en = 1'b0;

        // Last beat coincides with load_done and must still land.
        for (int k = 0; k < 3; k++) begin
            bus.load_valid = 1'b1; bus.load_addr = 32'(k); bus.load_data = iw[k];
            bus.load_done = (k == 2);
            tick();
        end
        bus.load_valid = 1'b0; bus.load_done = 1'b0;
        check("run_state", 32'(state), 32'd1);
        check("run_core_rst", 32'(bus.core_rst), 32'd1);
        check("run_load_ready", 32'(bus.load_ready), 32'd0);

        for (int i = 0; i < 7; i++) begin
            bus.core_addr = vt[i].iaddr; bus.core_mem_addr = vt[i].daddr;
            bus.core_en = vt[i].en; bus.core_rw = 1'b0;
            #1;
            check($sformatf("vec%0d_din", i), bus.core_din, vt[i].exp_din);
            check($sformatf("vec%0d_ddatin", i), bus.core_ddatin, vt[i].exp_ddat);
            tick();
            check($sformatf("vec%0d_bus_err", i), 32'(bus_err), 32'(vt[i].exp_berr));
        end
        bus.core_en = 1'b0;
        tick();
        check("bus_err_pulse", 32'(bus_err), 32'd0);

        // Stores while the debug port holds off the drain.
        bus.dbg_wr_en = 1'b1; bus.dbg_addr = 32'd3; bus.dbg_wdata = 32'h55;
        bus.core_en = 1'b1; bus.core_rw = 1'b1; bus.core_mem_addr = 32'h8; bus.core_ddatout = 32'hDEAD_BEEF;
        tick();
        bus.core_rw = 1'b0;
        #1;
        check("fwd_read", bus.core_ddatin, 32'hDEAD_BEEF);
        check("wbuf_count_1", 32'(wbuf_count), WBUF ? 32'd1 : 32'd0);
        tick();
        bus.core_rw = 1'b1; bus.core_mem_addr = 32'hC; bus.core_ddatout = 32'h11;
        tick();
        bus.core_ddatout = 32'h22;
        tick();
        bus.core_rw = 1'b0;
        #1;
        check("youngest_fwd", bus.core_ddatin, 32'h22);
        check("wbuf_count_3", 32'(wbuf_count), WBUF ? 32'd3 : 32'd0);
        tick();
        bus.dbg_wr_en = 1'b0; bus.core_en = 1'b0;
        repeat (4) tick();
        check("wbuf_drained", 32'(wbuf_count), 32'd0);
        dbg_read(32'd2, 32'hDEAD_BEEF);
        dbg_read(32'd3, 32'h22);

        bus.dbg_wr_en = 1'b1; bus.dbg_addr = 32'd1; bus.dbg_wdata = 32'hBAD0;
        tick();
        bus.dbg_wr_en = 1'b0;
        dbg_read(32'd1, WBUF ? 32'hBAD0 : dw[1]);

        // Fill, drain-and-enqueue at full, then overflow.
        for (int k = 0; k < 6; k++) begin
            bus.dbg_wr_en = (k != 4); bus.dbg_addr = 32'd50; bus.dbg_wdata = '0;
            bus.core_en = 1'b1; bus.core_rw = 1'b1;
            bus.core_mem_addr = 32'h20 + 32'(4 * k); bus.core_ddatout = 32'h100 + 32'(k);
            tick();
            if (k == 3) check("wbuf_full", 32'(wbuf_count), WBUF ? 32'd4 : 32'd0);
            if (k == 4) begin
                check("enq_deq_full_count", 32'(wbuf_count), WBUF ? 32'd4 : 32'd0);
                check("enq_deq_full_ovf", 32'(ovf_err), 32'd0);
                check("enq_deq_full_state", 32'(state), 32'd1);
            end
        end
        bus.core_rw = 1'b0; bus.core_mem_addr = 32'h30;
        #1;
        check("ovf_err", 32'(ovf_err), WBUF ? 32'd1 : 32'd0);
        check("ovf_state", 32'(state), WBUF ? 32'd2 : 32'd1);
        check("ovf_core_rst", 32'(bus.core_rst), WBUF ? 32'd0 : 32'd1);
        check("ovf_count", 32'(wbuf_count), WBUF ? 32'd4 : 32'd0);
        check("store_k4_read", bus.core_ddatin, 32'h104);
        tick();
        check("ovf_sticky", 32'(ovf_err), WBUF ? 32'd1 : 32'd0);

        // Reset mid-operation with the drain still stalled.
        bus.core_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_state", 32'(state), 32'd0);
        check("rst2_count", 32'(wbuf_count), 32'd0);
        check("rst2_load_ready", 32'(bus.load_ready), 32'd1);
        check("rst2_ovf_err", 32'(ovf_err), 32'd0);
        bus.dbg_wr_en = 1'b0;

        bus.load_done = 1'b1;
        tick();
        bus.load_done = 1'b0;
        check("boot2_state", 32'(state), 32'd1);
        bus.core_trap = 1'b1;
        tick();
        bus.core_trap = 1'b0;
        check("trap_state", 32'(state), 32'd2);
        check("trap_core_rst", 32'(bus.core_rst), 32'd0);
        bus.load_done = 1'b1;
        tick();
        tick();
        bus.load_done = 1'b0;
        check("fault_sticky", 32'(state), 32'd2);

        bus.dbg_wr_en = 1'b1; bus.dbg_addr = 32'd6; bus.dbg_wdata = 32'h66;
        tick();
        bus.dbg_wr_en = 1'b0;
        bus.core_en = 1'b1; bus.core_rw = 1'b1; bus.core_mem_addr = 32'h18; bus.core_ddatout = 32'h99;
        tick();
        bus.core_en = 1'b0; bus.core_rw = 1'b0;
        tick();
        dbg_read(32'd6, 32'h66);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst3_state", 32'(state), 32'd0);
        check("rst3_load_ready", 32'(bus.load_ready), 32'd1);
        check("rst3_core_rst", 32'(bus.core_rst), 32'd0);
        tick();
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
